// File: rtl/key_onehot_capture_if.sv
// rtl/key_onehot_capture_if.sv - key lines in, captured one-hot key code out
interface key_onehot_capture_if;
    logic [7:0] iKey;
    logic       iClear;
    logic [7:0] oData;
    logic       oValid;
    logic       oPress;
    logic       oMulti;

    modport master (
        output iKey,
        output iClear,
        input  oData,
        input  oValid,
        input  oPress,
        input  oMulti
    );

    modport slave (
        input  iKey,
        input  iClear,
        output oData,
        output oValid,
        output oPress,
        output oMulti
    );
endinterface

// File: rtl/key_onehot_capture.sv
// rtl/key_onehot_capture.sv - debounce eight keys and hold one accepted press as one-hot
module key_onehot_capture #(
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 4
) (
    input  logic                  iClk,
    input  logic                  iRst,
    key_onehot_capture_if.slave   bus
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HOLD,
        ST_BLOCK
    } state_t;

    logic [7:0]        sync1_q, sync1_d;
    logic [7:0]        ks_q, ks_d;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic              tick;
    logic [7:0][3:0]   cnt_q, cnt_d;
    logic [7:0]        db_q, db_d;
    state_t            state_q, state_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              press_q, press_d;
    logic              multi_q, multi_d;
    logic              db_zero;
    logic              db_onehot;

    // Two-stage synchronizer and free-running sample-tick divider
    always_comb begin
        sync1_d    = bus.iKey;
        ks_d       = sync1_q;
        tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    end

    // Per-bit debounce: a bit flips only after STABLE_TICKS consecutive disagreeing ticks
    always_comb begin
        cnt_d = cnt_q;
        db_d  = db_q;
        if (tick) begin
            for (int i = 0; i < 8; i++) begin
                if (ks_q[i] != db_q[i]) begin
                    if (cnt_q[i] + 4'd1 == 4'(STABLE_TICKS)) begin
                        db_d[i]  = ~db_q[i];
                        cnt_d[i] = 4'd0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 4'd1;
                    end
                end else begin
                    cnt_d[i] = 4'd0;
                end
            end
        end
    end

    // Capture FSM: accept a lone key from IDLE, reject chords, wait for full release
    always_comb begin
        db_zero   = (db_q == 8'h00);
        db_onehot = !db_zero && ((db_q & (db_q - 8'h01)) == 8'h00);
        state_d   = state_q;
        data_d    = data_q;
        valid_d   = valid_q;
        press_d   = 1'b0;
        multi_d   = 1'b0;
        // Clear first so an IDLE capture in the same cycle overrides it
        if (bus.iClear) begin
            data_d  = 8'h00;
            valid_d = 1'b0;
        end
        case (state_q)
            ST_IDLE: begin
                if (db_onehot) begin
                    data_d  = db_q;
                    valid_d = 1'b1;
                    press_d = 1'b1;
                    state_d = ST_HOLD;
                end else if (!db_zero) begin
                    multi_d = 1'b1;
                    state_d = ST_BLOCK;
                end
            end
            ST_HOLD, ST_BLOCK: begin
                if (db_zero) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register with asynchronous reset of every stage
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            sync1_q    <= '0;
            ks_q       <= '0;
            tick_cnt_q <= '0;
            cnt_q      <= '0;
            db_q       <= '0;
            state_q    <= ST_IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            press_q    <= 1'b0;
            multi_q    <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            ks_q       <= ks_d;
            tick_cnt_q <= tick_cnt_d;
            cnt_q      <= cnt_d;
            db_q       <= db_d;
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            press_q    <= press_d;
            multi_q    <= multi_d;
        end
    end

    assign bus.oData  = data_q;
    assign bus.oValid = valid_q;
    assign bus.oPress = press_q;
    assign bus.oMulti = multi_q;

endmodule

// File: tb/tb_key_onehot_capture.sv
// tb/tb_key_onehot_capture.sv - directed self-checking bench for key_onehot_capture
`timescale 1ns/1ps
module tb_key_onehot_capture;

    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;
    int   press_count;
    int   multi_count;
    int   p0;
    int   m0;
    int   n;

    key_onehot_capture_if bus ();

    key_onehot_capture #(
        .TICK_DIV     (4),
        .STABLE_TICKS (3)
    ) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] encode(input logic [7:0] d);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (d[i]) r = 3'(i);
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    // Pulse counting and legal-output checks, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.oPress) press_count++;
        if (bus.oMulti) multi_count++;
        n_asserts++;
        assert (((bus.oData & (bus.oData - 8'h01)) == 8'h00)
                && (bus.oValid == (bus.oData != 8'h00))
                && !(bus.oPress && bus.oMulti)) else begin
            n_fail++;
            $error("FAIL invariant: observed data=%0h valid=%0b press=%0b multi=%0b expected legal one-hot set",
                   bus.oData, bus.oValid, bus.oPress, bus.oMulti);
        end
    end

    initial begin
        n_asserts   = 0;
        n_fail      = 0;
        press_count = 0;
        multi_count = 0;
        rst         = 1'b1;
        bus.iKey    = 8'h00;
        bus.iClear  = 1'b0;

        // Reset and basic capture
        wait_cycles(3);
        check("rst_data",  bus.oData,  8'h00);
        check("rst_valid", bus.oValid, 1'b0);
        check("rst_press", bus.oPress, 1'b0);
        check("rst_multi", bus.oMulti, 1'b0);
        rst = 1'b0;
        wait_cycles(1);
        check("pre_data", bus.oData, 8'h00);
        bus.iKey = 8'h20;
        n = 0;
        while (n < 20 && !bus.oPress) begin
            wait_cycles(1);
            n++;
        end
        check("press_latency", n, 12);
        check("cap_data",  bus.oData,  8'h20);
        check("cap_valid", bus.oValid, 1'b1);
        check("cap_enc",   encode(bus.oData), 3'd5);
        wait_cycles(1);
        check("press_one_cycle", bus.oPress, 1'b0);
        bus.iKey = 8'h00;
        wait_cycles(20);
        check("after_release_data", bus.oData, 8'h20);
        check("first_press_count", press_count, 1);

        // Bounce rejection
        p0 = press_count;
        for (int s = 0; s < 12; s++) begin
            bus.iKey = (s % 2 == 0) ? 8'h08 : 8'h00;
            wait_cycles(5);
        end
        bus.iKey = 8'h00;
        wait_cycles(20);
        check("bounce_no_press", press_count, p0);
        check("bounce_data", bus.oData, 8'h20);
        bus.iKey = 8'h08;
        wait_cycles(20);
        check("steady_press", press_count, p0 + 1);
        check("steady_data", bus.oData, 8'h08);
        bus.iKey = 8'h00;
        wait_cycles(20);

        // Chord rejection
        p0 = press_count;
        m0 = multi_count;
        bus.iKey = 8'h81;
        wait_cycles(20);
        check("chord_multi", multi_count, m0 + 1);
        check("chord_no_press", press_count, p0);
        check("chord_data", bus.oData, 8'h08);
        check("chord_valid", bus.oValid, 1'b1);
        bus.iKey = 8'h00;
        wait_cycles(20);
        bus.iKey = 8'h04;
        wait_cycles(20);
        check("post_chord_press", press_count, p0 + 1);
        check("post_chord_data", bus.oData, 8'h04);
        bus.iKey = 8'h00;
        wait_cycles(20);

        // Hold-over
        p0 = press_count;
        m0 = multi_count;
        bus.iKey = 8'h02;
        wait_cycles(20);
        check("hold_data", bus.oData, 8'h02);
        bus.iKey = 8'h42;
        wait_cycles(20);
        bus.iKey = 8'h40;
        wait_cycles(20);
        check("holdover_data", bus.oData, 8'h02);
        check("holdover_press", press_count, p0 + 1);
        check("holdover_multi", multi_count, m0);
        bus.iKey = 8'h00;
        wait_cycles(20);
        bus.iKey = 8'h40;
        wait_cycles(20);
        check("second_key_data", bus.oData, 8'h40);
        bus.iKey = 8'h00;
        wait_cycles(20);

        // Clear
        bus.iKey = 8'h10;
        wait_cycles(20);
        check("clear_pre_data", bus.oData, 8'h10);
        p0 = press_count;
        bus.iClear = 1'b1;
        wait_cycles(1);
        bus.iClear = 1'b0;
        check("clear_data",  bus.oData,  8'h00);
        check("clear_valid", bus.oValid, 1'b0);
        wait_cycles(20);
        check("clear_no_recap_data", bus.oData, 8'h00);
        check("clear_no_recap_press", press_count, p0);
        bus.iKey = 8'h00;
        wait_cycles(20);
        bus.iKey = 8'h10;
        wait_cycles(20);
        check("reclear_data", bus.oData, 8'h10);

        // Asynchronous reset mid-hold with a debounce counter running
        bus.iKey = 8'h11;
        wait_cycles(7);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_data",  bus.oData,  8'h00);
        check("async_valid", bus.oValid, 1'b0);
        bus.iKey = 8'h10;
        wait_cycles(3);
        rst = 1'b0;
        n = 0;
        while (n < 20 && !bus.oPress) begin
            wait_cycles(1);
            n++;
        end
        check("recap_latency", n, 13);
        check("recap_data", bus.oData, 8'h10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
